rename_unit: RTL and testbench
==============================

Name: rename_unit

Overview:
- Parametrised, clocked successor to the 2-wide combinational rename.
- Renames a group of WIDTH decoded instructions per cycle against a speculative RAT and a free-list of physical registers.
- Returns the old mapping of each destination so the ROB can free it at retire.
- Sits between decode and dispatch. Has a valid/ready handshake on both sides, a retire-side free port, and a 1-cycle registered output.

Parameters:
- WIDTH, 2, instructions renamed per group (1..4)
- NUM_AREGS, 32, architectural registers
- NUM_PREGS, 128, physical registers (> NUM_AREGS + WIDTH)
- AREG_W, $clog2(NUM_AREGS), architectural index width
- PREG_W, $clog2(NUM_PREGS), physical index width (7 for 128)

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  decode group valid
- in_ready  out  1  group accepted when in_valid && in_ready
- in_lane_vld  in  WIDTH  per-lane instruction present
- in_rd_we  in  WIDTH  lane writes rd (0 for SW/branch)
- in_rs1  in  WIDTH*AREG_W  source 1 per lane
- in_rs2  in  WIDTH*AREG_W  source 2 per lane
- in_rd  in  WIDTH*AREG_W  destination per lane
- out_valid  out  1  renamed group valid
- out_ready  in  1  dispatch can take group
- out_lane_vld  out  WIDTH  registered copy of in_lane_vld
- out_ps1  out  WIDTH*PREG_W  physical source 1
- out_ps2  out  WIDTH*PREG_W  physical source 2
- out_pd  out  WIDTH*PREG_W  newly allocated destination (0 if none)
- out_old_pd  out  WIDTH*PREG_W  previous mapping of rd (0 if none)
- free_valid  in  WIDTH  retire frees a preg per lane
- free_preg  in  WIDTH*PREG_W  preg to return
- err_double_free  out  1  sticky error flag

Behaviour:
- Reset (rst_n low at posedge):
  - RAT[i]=i.
  - pregs 0..NUM_AREGS-1 busy, rest free; free_count=NUM_PREGS-NUM_AREGS.
  - out_valid=0, all out_* data=0, err_double_free=0.
  - Reset mid-operation discards any held group.
- Allocating lane: lane_vld && rd_we && rd!=0. Only allocating lanes consume a preg or update the RAT.
- Non-allocating lane (including rd=x0): pd=0, old_pd=0.
- in_ready = (free_count >= WIDTH) && (!out_valid || out_ready).
  - The threshold is conservative, so there is no combinational path from lane data to in_ready.
- Allocation: allocating lanes in ascending lane order take the lowest-numbered free pregs in ascending order.
- Source lookup per lane j, for rs1 and rs2:
  - if any earlier lane i<j in the same group allocates with rd==rs, use pd of the highest such i (intra-group bypass);
  - else use RAT[rs].
  - rs==0 always gives preg 0.
- old_pd per lane j: pd of the highest earlier lane writing the same rd, else RAT[rd].
- RAT update on accept: the last lane writing a given rd wins.
- Output register:
  - loaded on accept, latency 1 cycle;
  - held stable while out_valid && !out_ready;
  - out_valid cleared when out_ready && no new accept.
- Free port:
  - each free_valid lane sets its preg free at the clock edge;
  - a freed preg is allocatable from the next cycle, never in the same cycle.
- free_count_next = free_count + accepted frees - allocations.
- Invalid frees (preg 0, preg already free, or the same preg on two free lanes in one cycle): ignored, no count change, err_double_free set until reset.
- Simultaneous accept and free in one cycle are both applied.

Decomposition:
- Package rename_pkg:
  - NUM_AREGS, NUM_PREGS, AREG_W, PREG_W
  - typedefs areg_t, preg_t
  - rename_lane_t struct {vld, ps1, ps2, pd, old_pd}
- Sub-module free_list:
  - busy bit-vector, WIDTH-way lowest-free priority allocator, free_count, free-port handling, double-free detection.
- The RAT and bypass logic stay in rename_unit.

Test Plan:
- Reset, then lane0 {rs1=5, rs2=6, rd=7, rd_we=1}, lane1 invalid -> next cycle out_valid=1, ps1=5, ps2=6, pd=32, old_pd=7; free_count 96->95.
- Lane0 rd=3, lane1 {rs1=3, rd=3} -> lane0 pd=32, old_pd=3; lane1 ps1=32, pd=33, old_pd=32. Next group rs1=3 -> ps1=33.
- Lane0 rd=0 rd_we=1, lane1 rd_we=0 -> pd=0, old_pd=0 both lanes; free_count unchanged at 96.
- 48 full two-lane groups -> free_count=0, in_ready=0. Free p40,p41 -> in_ready=1 the following cycle. Next group gets pd=40,41.
- out_ready=0 with out_valid=1 -> outputs bit-stable, in_ready=0, RAT unchanged. Raise out_ready -> queued group accepted next cycle.
- Free p0, or free p100 while p100 is free -> err_double_free=1 (sticky), free_count unchanged.

Source files
------------

// File: rtl/rename_pkg.sv
// rename_pkg: shared widths, register index types and the per-lane rename record
package rename_pkg;
    localparam int NUM_AREGS = 32;
    localparam int NUM_PREGS = 128;
    localparam int AREG_W    = $clog2(NUM_AREGS);
    localparam int PREG_W    = $clog2(NUM_PREGS);

    typedef logic [AREG_W-1:0] areg_t;
    typedef logic [PREG_W-1:0] preg_t;

    typedef struct packed {
        logic  vld;
        preg_t ps1;
        preg_t ps2;
        preg_t pd;
        preg_t old_pd;
    } rename_lane_t;
endpackage

// File: rtl/rename_unit_free_list.sv
// free_list: physical register busy map, lowest-free allocator and retire-side free port
//   alloc / alloc_en        lanes needing a preg / commit those allocations this cycle
//   alloc_pd                preg granted per lane (0 for lanes not allocating)
//   free_valid / free_preg  pregs returned by retire
//   free_count              number of free pregs
//   err_double_free         sticky flag for frees of p0, of a free preg, or duplicated in one cycle
module free_list #(
    parameter int WIDTH     = 2,
    parameter int NUM_AREGS = 32,
    parameter int NUM_PREGS = 128,
    parameter int PREG_W    = $clog2(NUM_PREGS),
    parameter int CNT_W     = $clog2(NUM_PREGS + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [WIDTH-1:0]        alloc,
    input  logic                    alloc_en,
    output logic [WIDTH*PREG_W-1:0] alloc_pd,
    input  logic [WIDTH-1:0]        free_valid,
    input  logic [WIDTH*PREG_W-1:0] free_preg,
    output logic [CNT_W-1:0]        free_count,
    output logic                    err_double_free
);
    logic [NUM_PREGS-1:0] busy;
    logic [PREG_W-1:0]    cand [WIDTH];
    logic [PREG_W-1:0]    pd [WIDTH];
    logic [PREG_W-1:0]    fp [WIDTH];
    logic [WIDTH-1:0]     free_ok;
    logic [WIDTH-1:0]     free_bad;
    logic [CNT_W-1:0]     n_alloc;
    logic [CNT_W-1:0]     n_free;
    int                   n;
    int                   r;

    for (genvar j = 0; j < WIDTH; j++) begin : g_lane
        assign fp[j] = free_preg[j*PREG_W +: PREG_W];
        assign alloc_pd[j*PREG_W +: PREG_W] = pd[j];
    end

    // The WIDTH lowest-numbered free pregs, ascending.
    always_comb begin
        n = 0;
        for (int k = 0; k < WIDTH; k++)
            cand[k] = '0;
        for (int p = 0; p < NUM_PREGS; p++) begin
            if (!busy[p] && n < WIDTH) begin
                cand[n] = PREG_W'(p);
                n = n + 1;
            end
        end
    end

    // Allocating lanes take candidates in lane order, skipping lanes that do not allocate.
    always_comb begin
        r = 0;
        n_alloc = '0;
        for (int j = 0; j < WIDTH; j++) begin
            pd[j] = alloc[j] ? cand[r] : '0;
            r = r + (alloc[j] ? 1 : 0);
            n_alloc = n_alloc + CNT_W'(alloc[j]);
        end
    end

    // A duplicated preg across free lanes rejects every copy of it.
    always_comb begin
        n_free = '0;
        for (int j = 0; j < WIDTH; j++) begin
            free_ok[j] = free_valid[j] && fp[j] != '0 && busy[fp[j]];
            for (int i = 0; i < WIDTH; i++)
                if (i != j && free_valid[i] && fp[i] == fp[j])
                    free_ok[j] = 1'b0;
            free_bad[j] = free_valid[j] && !free_ok[j];
            n_free = n_free + CNT_W'(free_ok[j]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy <= {{(NUM_PREGS-NUM_AREGS){1'b0}}, {NUM_AREGS{1'b1}}};
            free_count <= CNT_W'(NUM_PREGS - NUM_AREGS);
            err_double_free <= 1'b0;
        end else begin
            for (int j = 0; j < WIDTH; j++)
                if (alloc_en && alloc[j])
                    busy[pd[j]] <= 1'b1;
            for (int j = 0; j < WIDTH; j++)
                if (free_ok[j])
                    busy[fp[j]] <= 1'b0;
            free_count <= free_count + n_free - (alloc_en ? n_alloc : '0);
            if (|free_bad)
                err_double_free <= 1'b1;
        end
    end
endmodule

// File: rtl/rename_unit.sv
// rename_unit: WIDTH-wide register rename with speculative RAT, intra-group bypass and registered output
//   in_valid/in_ready, in_lane_vld, in_rd_we, in_rs1/rs2/rd   decode-side group
//   out_valid/out_ready, out_lane_vld, out_ps1/ps2/pd/old_pd  dispatch-side renamed group
//   free_valid/free_preg                                     retire-side preg returns
//   err_double_free                                          sticky invalid-free flag
module rename_unit #(
    parameter int WIDTH     = 2,
    parameter int NUM_AREGS = 32,
    parameter int NUM_PREGS = 128,
    parameter int AREG_W    = $clog2(NUM_AREGS),
    parameter int PREG_W    = $clog2(NUM_PREGS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_lane_vld,
    input  logic [WIDTH-1:0]        in_rd_we,
    input  logic [WIDTH*AREG_W-1:0] in_rs1,
    input  logic [WIDTH*AREG_W-1:0] in_rs2,
    input  logic [WIDTH*AREG_W-1:0] in_rd,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_lane_vld,
    output logic [WIDTH*PREG_W-1:0] out_ps1,
    output logic [WIDTH*PREG_W-1:0] out_ps2,
    output logic [WIDTH*PREG_W-1:0] out_pd,
    output logic [WIDTH*PREG_W-1:0] out_old_pd,
    input  logic [WIDTH-1:0]        free_valid,
    input  logic [WIDTH*PREG_W-1:0] free_preg,
    output logic                    err_double_free
);
    import rename_pkg::*;

    localparam int CNT_W = $clog2(NUM_PREGS + 1);

    logic [PREG_W-1:0]       rat [NUM_AREGS];
    logic [AREG_W-1:0]       rs1 [WIDTH];
    logic [AREG_W-1:0]       rs2 [WIDTH];
    logic [AREG_W-1:0]       rd [WIDTH];
    logic [PREG_W-1:0]       pd [WIDTH];
    logic [WIDTH*PREG_W-1:0] alloc_pd;
    logic [WIDTH-1:0]        alloc;
    logic [CNT_W-1:0]        free_count;
    logic                    accept;
    rename_lane_t            lane_d [WIDTH];
    rename_lane_t            lane_q [WIDTH];

    for (genvar j = 0; j < WIDTH; j++) begin : g_lane
        assign rs1[j] = in_rs1[j*AREG_W +: AREG_W];
        assign rs2[j] = in_rs2[j*AREG_W +: AREG_W];
        assign rd[j]  = in_rd[j*AREG_W +: AREG_W];
        assign pd[j]  = alloc_pd[j*PREG_W +: PREG_W];
        assign alloc[j] = in_lane_vld[j] && in_rd_we[j] && rd[j] != '0;
        assign out_lane_vld[j] = lane_q[j].vld;
        assign out_ps1[j*PREG_W +: PREG_W]    = lane_q[j].ps1;
        assign out_ps2[j*PREG_W +: PREG_W]    = lane_q[j].ps2;
        assign out_pd[j*PREG_W +: PREG_W]     = lane_q[j].pd;
        assign out_old_pd[j*PREG_W +: PREG_W] = lane_q[j].old_pd;
    end

    // Gate on the worst-case allocation count so lane data never reaches in_ready.
    assign in_ready = free_count >= CNT_W'(WIDTH) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    free_list #(
        .WIDTH(WIDTH), .NUM_AREGS(NUM_AREGS), .NUM_PREGS(NUM_PREGS), .PREG_W(PREG_W), .CNT_W(CNT_W)
    ) u_free_list (
        .clk(clk), .rst_n(rst_n), .alloc(alloc), .alloc_en(accept), .alloc_pd(alloc_pd),
        .free_valid(free_valid), .free_preg(free_preg), .free_count(free_count),
        .err_double_free(err_double_free)
    );

    // RAT[0] is never written, so x0 sources resolve to p0 without a special case.
    // Scanning earlier lanes in ascending order lets the highest matching lane win.
    always_comb begin
        for (int j = 0; j < WIDTH; j++) begin
            lane_d[j].vld    = in_lane_vld[j];
            lane_d[j].ps1    = rat[rs1[j]];
            lane_d[j].ps2    = rat[rs2[j]];
            lane_d[j].pd     = pd[j];
            lane_d[j].old_pd = alloc[j] ? rat[rd[j]] : '0;
            for (int i = 0; i < j; i++) begin
                if (alloc[i] && rd[i] == rs1[j])
                    lane_d[j].ps1 = pd[i];
                if (alloc[i] && rd[i] == rs2[j])
                    lane_d[j].ps2 = pd[i];
                if (alloc[i] && alloc[j] && rd[i] == rd[j])
                    lane_d[j].old_pd = pd[i];
            end
        end
    end

    // Later lanes are written last, so the youngest writer of an rd wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_AREGS; i++)
                rat[i] <= PREG_W'(i);
        end else if (accept) begin
            for (int j = 0; j < WIDTH; j++)
                if (alloc[j])
                    rat[rd[j]] <= pd[j];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            for (int j = 0; j < WIDTH; j++)
                lane_q[j] <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            for (int j = 0; j < WIDTH; j++)
                lane_q[j] <= lane_d[j];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_rename_unit.sv
// tb_rename_unit: directed checks of rename, bypass, exhaustion, back-pressure and free-port errors
module tb_rename_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_lane_vld = '0;
    logic [1:0]  in_rd_we = '0;
    logic [9:0]  in_rs1 = '0;
    logic [9:0]  in_rs2 = '0;
    logic [9:0]  in_rd = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [1:0]  out_lane_vld;
    logic [13:0] out_ps1;
    logic [13:0] out_ps2;
    logic [13:0] out_pd;
    logic [13:0] out_old_pd;
    logic [1:0]  free_valid = '0;
    logic [13:0] free_preg = '0;
    logic        err_double_free;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    rename_unit dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_lane_vld(in_lane_vld), .in_rd_we(in_rd_we), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_lane_vld(out_lane_vld),
        .out_ps1(out_ps1), .out_ps2(out_ps2), .out_pd(out_pd), .out_old_pd(out_old_pd),
        .free_valid(free_valid), .free_preg(free_preg), .err_double_free(err_double_free)
    );

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        free_valid = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Presents one group and waits (bounded) for it to be taken; ok reports acceptance.
    task automatic send(input logic [1:0] lv, input logic [1:0] we, input logic [9:0] s1,
                        input logic [9:0] s2, input logic [9:0] d, output logic ok);
        in_valid = 1'b1;
        in_lane_vld = lv;
        in_rd_we = we;
        in_rs1 = s1;
        in_rs2 = s2;
        in_rd = d;
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic do_free(input logic [1:0] fv, input logic [13:0] fpr);
        free_valid = fv;
        free_preg = fpr;
        @(posedge clk);
        #1;
        free_valid = '0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if ({out_ps1, out_ps2, out_pd, out_old_pd, out_lane_vld} !== '0) begin bad++; $display("FAIL reset_out_data got=%h exp=0", {out_ps1, out_ps2, out_pd, out_old_pd}); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if (err_double_free !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err_double_free); end
        total++; if (dut.u_free_list.free_count !== 8'd96) begin bad++; $display("FAIL reset_free_count got=%0d exp=96", dut.u_free_list.free_count); end
    endtask

    task automatic test_basic();
        logic ok;
        do_reset();
        send(2'b01, 2'b01, {5'd0, 5'd5}, {5'd0, 5'd6}, {5'd0, 5'd7}, ok);
        total++; if (ok !== 1'b1 || out_valid !== 1'b1) begin bad++; $display("FAIL basic_accept got=%b/%b exp=1/1", ok, out_valid); end
        total++; if (out_ps1 !== {7'd0, 7'd5} || out_ps2 !== {7'd0, 7'd6}) begin bad++; $display("FAIL basic_src got=%h/%h exp=%h/%h", out_ps1, out_ps2, {7'd0, 7'd5}, {7'd0, 7'd6}); end
        total++; if (out_pd !== {7'd0, 7'd32} || out_old_pd !== {7'd0, 7'd7}) begin bad++; $display("FAIL basic_dst got=%h/%h exp=%h/%h", out_pd, out_old_pd, {7'd0, 7'd32}, {7'd0, 7'd7}); end
        total++; if (out_lane_vld !== 2'b01) begin bad++; $display("FAIL basic_lane_vld got=%b exp=01", out_lane_vld); end
        total++; if (dut.u_free_list.free_count !== 8'd95) begin bad++; $display("FAIL basic_free_count got=%0d exp=95", dut.u_free_list.free_count); end
        @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_bypass();
        logic ok;
        do_reset();
        send(2'b11, 2'b11, {5'd3, 5'd1}, {5'd0, 5'd2}, {5'd3, 5'd3}, ok);
        total++; if (out_ps1 !== {7'd32, 7'd1} || out_ps2 !== {7'd0, 7'd2}) begin bad++; $display("FAIL bypass_src got=%h/%h exp=%h/%h", out_ps1, out_ps2, {7'd32, 7'd1}, {7'd0, 7'd2}); end
        total++; if (out_pd !== {7'd33, 7'd32}) begin bad++; $display("FAIL bypass_pd got=%h exp=%h", out_pd, {7'd33, 7'd32}); end
        total++; if (out_old_pd !== {7'd32, 7'd3}) begin bad++; $display("FAIL bypass_old_pd got=%h exp=%h", out_old_pd, {7'd32, 7'd3}); end
        send(2'b01, 2'b00, {5'd0, 5'd3}, 10'd0, 10'd0, ok);
        total++; if (out_ps1 !== {7'd0, 7'd33} || out_pd !== '0 || out_old_pd !== '0) begin bad++; $display("FAIL bypass_rat_last_wins got=%h/%h/%h exp=%h/0/0", out_ps1, out_pd, out_old_pd, {7'd0, 7'd33}); end
        total++; if (dut.u_free_list.free_count !== 8'd94) begin bad++; $display("FAIL bypass_free_count got=%0d exp=94", dut.u_free_list.free_count); end
    endtask

    task automatic test_x0();
        logic ok;
        do_reset();
        send(2'b11, 2'b01, {5'd0, 5'd4}, 10'd0, {5'd5, 5'd0}, ok);
        total++; if (out_pd !== '0 || out_old_pd !== '0) begin bad++; $display("FAIL x0_dst got=%h/%h exp=0/0", out_pd, out_old_pd); end
        total++; if (out_ps1 !== {7'd0, 7'd4}) begin bad++; $display("FAIL x0_src got=%h exp=%h", out_ps1, {7'd0, 7'd4}); end
        total++; if (dut.u_free_list.free_count !== 8'd96) begin bad++; $display("FAIL x0_free_count got=%0d exp=96", dut.u_free_list.free_count); end
    endtask

    task automatic test_exhaust();
        logic ok;
        logic all_ok;
        do_reset();
        all_ok = 1'b1;
        for (int g = 0; g < 48; g++) begin
            send(2'b11, 2'b11, 10'd0, 10'd0, {5'd2, 5'd1}, ok);
            all_ok = all_ok & ok;
        end
        total++; if (all_ok !== 1'b1) begin bad++; $display("FAIL exhaust_accepts got=%b exp=1", all_ok); end
        total++; if (out_pd !== {7'd127, 7'd126} || out_old_pd !== {7'd125, 7'd124}) begin bad++; $display("FAIL exhaust_last got=%h/%h exp=%h/%h", out_pd, out_old_pd, {7'd127, 7'd126}, {7'd125, 7'd124}); end
        total++; if (dut.u_free_list.free_count !== 8'd0 || in_ready !== 1'b0) begin bad++; $display("FAIL exhaust_empty got=%0d/%b exp=0/0", dut.u_free_list.free_count, in_ready); end
        do_free(2'b11, {7'd41, 7'd40});
        total++; if (dut.u_free_list.free_count !== 8'd2 || in_ready !== 1'b1) begin bad++; $display("FAIL exhaust_refill got=%0d/%b exp=2/1", dut.u_free_list.free_count, in_ready); end
        send(2'b11, 2'b11, 10'd0, 10'd0, {5'd2, 5'd1}, ok);
        total++; if (ok !== 1'b1 || out_pd !== {7'd41, 7'd40} || out_old_pd !== {7'd127, 7'd126}) begin bad++; $display("FAIL exhaust_reuse got=%b/%h/%h exp=1/%h/%h", ok, out_pd, out_old_pd, {7'd41, 7'd40}, {7'd127, 7'd126}); end
    endtask

    task automatic test_back_to_back();
        logic ok;
        logic [57:0] snap;
        do_reset();
        out_ready = 1'b0;
        send(2'b01, 2'b01, {5'd0, 5'd5}, {5'd0, 5'd6}, {5'd0, 5'd7}, ok);
        snap = {out_ps1, out_ps2, out_pd, out_old_pd, out_lane_vld};
        in_valid = 1'b1;
        in_lane_vld = 2'b01;
        in_rd_we = 2'b01;
        in_rs1 = {5'd0, 5'd7};
        in_rs2 = 10'd0;
        in_rd = {5'd0, 5'd7};
        repeat (3) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL stall_handshake got=%b/%b exp=1/0", out_valid, in_ready); end
        total++; if ({out_ps1, out_ps2, out_pd, out_old_pd, out_lane_vld} !== snap) begin bad++; $display("FAIL stall_hold got=%h exp=%h", {out_ps1, out_ps2, out_pd, out_old_pd, out_lane_vld}, snap); end
        total++; if (dut.u_free_list.free_count !== 8'd95) begin bad++; $display("FAIL stall_free_count got=%0d exp=95", dut.u_free_list.free_count); end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        total++; if (out_ps1 !== {7'd0, 7'd32} || out_pd !== {7'd0, 7'd33} || out_old_pd !== {7'd0, 7'd32}) begin bad++; $display("FAIL stall_release got=%h/%h/%h exp=%h/%h/%h", out_ps1, out_pd, out_old_pd, {7'd0, 7'd32}, {7'd0, 7'd33}, {7'd0, 7'd32}); end
        out_ready = 1'b0;
        do_reset();
        total++; if (out_valid !== 1'b0 || out_pd !== '0 || dut.u_free_list.free_count !== 8'd96) begin bad++; $display("FAIL midop_reset got=%b/%h/%0d exp=0/0/96", out_valid, out_pd, dut.u_free_list.free_count); end
        send(2'b01, 2'b00, {5'd0, 5'd7}, 10'd0, 10'd0, ok);
        total++; if (out_ps1 !== {7'd0, 7'd7}) begin bad++; $display("FAIL midop_rat got=%h exp=%h", out_ps1, {7'd0, 7'd7}); end
    endtask

    task automatic test_double_free();
        logic ok;
        do_reset();
        do_free(2'b01, {7'd0, 7'd0});
        total++; if (err_double_free !== 1'b1 || dut.u_free_list.free_count !== 8'd96) begin bad++; $display("FAIL free_p0 got=%b/%0d exp=1/96", err_double_free, dut.u_free_list.free_count); end
        @(posedge clk);
        #1;
        total++; if (err_double_free !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", err_double_free); end
        do_reset();
        do_free(2'b01, {7'd0, 7'd100});
        total++; if (err_double_free !== 1'b1 || dut.u_free_list.free_count !== 8'd96) begin bad++; $display("FAIL free_already_free got=%b/%0d exp=1/96", err_double_free, dut.u_free_list.free_count); end
        do_reset();
        send(2'b01, 2'b01, 10'd0, 10'd0, {5'd0, 5'd7}, ok);
        do_free(2'b01, {7'd0, 7'd32});
        total++; if (err_double_free !== 1'b0 || dut.u_free_list.free_count !== 8'd96) begin bad++; $display("FAIL free_valid got=%b/%0d exp=0/96", err_double_free, dut.u_free_list.free_count); end
        send(2'b01, 2'b01, 10'd0, 10'd0, {5'd0, 5'd9}, ok);
        total++; if (out_pd !== {7'd0, 7'd32} || out_old_pd !== {7'd0, 7'd9}) begin bad++; $display("FAIL free_realloc got=%h/%h exp=%h/%h", out_pd, out_old_pd, {7'd0, 7'd32}, {7'd0, 7'd9}); end
        do_free(2'b11, {7'd32, 7'd32});
        total++; if (err_double_free !== 1'b1 || dut.u_free_list.free_count !== 8'd95) begin bad++; $display("FAIL free_dup_lanes got=%b/%0d exp=1/95", err_double_free, dut.u_free_list.free_count); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bypass();
        test_x0();
        test_exhaust();
        test_back_to_back();
        test_double_free();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
